// File: rtl/ex_stage.sv
// ex_stage: execute stage with single-cycle ALU ops and a 32-step iterative
// shift-add multiplier, sitting behind a one-entry output register with stall handshake.
module ex_stage #(
    parameter int REG_ADDRESS_SIZE = 5,
    parameter int REG_SIZE         = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          EX_valid_in,
    input  logic [REG_SIZE-1:0]           EX_operand1,
    input  logic [REG_SIZE-1:0]           EX_operand2,
    input  logic [2:0]                    EX_op,
    input  logic [REG_ADDRESS_SIZE+1:0]   EX_static_in,
    input  logic                          EX_stall_in,
    output logic                          EX_stall_out,
    output logic                          EX_valid_out,
    output logic [REG_SIZE-1:0]           EX_result,
    output logic [REG_ADDRESS_SIZE+1:0]   EX_static_out
);
    typedef enum logic {IDLE, MUL} state_t;

    state_t                        r_state, w_state_nx;
    logic [5:0]                    r_cnt;
    logic [REG_SIZE-1:0]           r_mcand, r_mplier, r_acc, r_result;
    logic [REG_ADDRESS_SIZE+1:0]   r_mstatic, r_static;
    logic                          r_valid;
    logic                          w_stall, w_accept, w_is_mul, w_free, w_mul_done;
    logic [REG_SIZE-1:0]           w_alu;

    assign w_stall       = (r_state == MUL) || (r_valid && EX_stall_in);
    assign w_accept      = EX_valid_in && !w_stall;
    assign w_is_mul      = EX_op == 3'b111;
    assign w_free        = !r_valid || !EX_stall_in;
    assign w_mul_done    = (r_state == MUL) && (r_cnt == 6'd32);
    assign EX_stall_out  = w_stall;
    assign EX_valid_out  = r_valid;
    assign EX_result     = r_result;
    assign EX_static_out = r_static;

    always_comb begin
        w_alu = '0;
        case (EX_op)
            3'b000:  w_alu = EX_operand1 + EX_operand2;
            3'b001:  w_alu = EX_operand1 - EX_operand2;
            3'b010:  w_alu = EX_operand1 & EX_operand2;
            3'b011:  w_alu = EX_operand1 | EX_operand2;
            3'b100:  w_alu = EX_operand1 ^ EX_operand2;
            3'b101:  w_alu = {{(REG_SIZE-1){1'b0}}, $signed(EX_operand1) < $signed(EX_operand2)};
            3'b110:  w_alu = EX_operand1 << EX_operand2[4:0];
            default: w_alu = '0;
        endcase
    end

    always_comb begin
        w_state_nx = r_state;
        if (r_state == IDLE && w_accept && w_is_mul)
            w_state_nx = MUL;
        else if (w_mul_done && w_free)
            w_state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_state <= IDLE;
        else
            r_state <= w_state_nx;
    end

    // Multiplier: one multiplier bit per cycle; counter parks at 32 while waiting for the output slot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_acc     <= '0;
            r_mstatic <= '0;
        end else if (w_accept && w_is_mul) begin
            r_cnt     <= '0;
            r_mcand   <= EX_operand1;
            r_mplier  <= EX_operand2;
            r_acc     <= '0;
            r_mstatic <= EX_static_in;
        end else if (r_state == MUL && r_cnt != 6'd32) begin
            if (r_mplier[0])
                r_acc <= r_acc + r_mcand;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 6'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid  <= 1'b0;
            r_result <= '0;
            r_static <= '0;
        end else if (w_accept && !w_is_mul) begin
            r_valid  <= 1'b1;
            r_result <= w_alu;
            r_static <= EX_static_in;
        end else if (w_mul_done && w_free) begin
            r_valid  <= 1'b1;
            r_result <= r_acc;
            r_static <= r_mstatic;
        end else if (r_valid && !EX_stall_in) begin
            r_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed checks of ex_stage ALU ops, multiplier latency, stall
// handshake and asynchronous reset, with hand-computed expected values.
module tb_ex_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic        EX_valid_in;
    logic [31:0] EX_operand1, EX_operand2;
    logic [2:0]  EX_op;
    logic [6:0]  EX_static_in;
    logic        EX_stall_in;
    logic        EX_stall_out, EX_valid_out;
    logic [31:0] EX_result;
    logic [6:0]  EX_static_out;
    int          n_assert = 0;
    int          n_fail = 0;
    logic        ok;

    ex_stage #(.REG_ADDRESS_SIZE(5), .REG_SIZE(32)) dut (
        .clk(clk), .reset(reset), .EX_valid_in(EX_valid_in),
        .EX_operand1(EX_operand1), .EX_operand2(EX_operand2), .EX_op(EX_op),
        .EX_static_in(EX_static_in), .EX_stall_in(EX_stall_in),
        .EX_stall_out(EX_stall_out), .EX_valid_out(EX_valid_out),
        .EX_result(EX_result), .EX_static_out(EX_static_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [6:0] s);
        EX_valid_in  = v;
        EX_op        = op;
        EX_operand1  = a;
        EX_operand2  = b;
        EX_static_in = s;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [31:0] r, input logic [6:0] s);
        chk({tag, "_valid"}, EX_valid_out, v);
        chk({tag, "_result"}, EX_result, r);
        chk({tag, "_static"}, EX_static_out, s);
    endtask

    initial begin
        reset = 1'b0;
        EX_stall_in = 1'b0;
        drive(0, 3'b000, 0, 0, 0);
        #3;
        chk_out("reset", 0, 32'h0, 7'h0);
        chk("reset_stall", EX_stall_out, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        drive(1, 3'b000, 32'hFFFF_FFFF, 32'h2, 7'h55);
        tick;
        chk_out("add_wrap", 1, 32'h1, 7'h55);
        drive(1, 3'b101, 32'hFFFF_FFFF, 32'h1, 7'h12);
        tick;
        chk_out("slt", 1, 32'h1, 7'h12);
        drive(1, 3'b110, 32'h1, 32'h21, 7'h13);
        tick;
        chk_out("sll", 1, 32'h2, 7'h13);
        drive(1, 3'b001, 32'h0, 32'h1, 7'h14);
        tick;
        chk("sub_wrap", EX_result, 32'hFFFF_FFFF);
        drive(1, 3'b010, 32'hF0F0_F0F0, 32'hFF00_FF00, 7'h15);
        tick;
        chk("and", EX_result, 32'hF000_F000);
        drive(1, 3'b011, 32'hF0F0_F0F0, 32'hFF00_FF00, 7'h16);
        tick;
        chk("or", EX_result, 32'hFFF0_FFF0);
        drive(1, 3'b100, 32'hF0F0_F0F0, 32'hFF00_FF00, 7'h17);
        tick;
        chk_out("xor", 1, 32'h0FF0_0FF0, 7'h17);
        drive(0, 3'b000, 0, 0, 0);
        tick;
        chk_out("consume", 0, 32'h0FF0_0FF0, 7'h17);

        drive(1, 3'b000, 32'h1, 32'h2, 7'h01);
        tick;
        chk_out("pre_stall", 1, 32'h3, 7'h01);
        EX_stall_in = 1'b1;
        drive(1, 3'b000, 32'h5, 32'h5, 7'h02);
        #1;
        chk("stall_out_comb", EX_stall_out, 1);
        ok = 1'b1;
        repeat (5) begin
            tick;
            if (EX_valid_out !== 1'b1 || EX_result !== 32'h3 || EX_static_out !== 7'h01 || EX_stall_out !== 1'b1)
                ok = 1'b0;
        end
        chk("stall_hold", ok, 1);
        EX_stall_in = 1'b0;
        #1;
        chk("stall_release", EX_stall_out, 0);
        tick;
        chk_out("after_stall", 1, 32'hA, 7'h02);
        drive(0, 3'b000, 0, 0, 0);
        tick;
        chk("drain", EX_valid_out, 0);

        drive(1, 3'b111, 32'h0001_2345, 32'h0001_0000, 7'h33);
        tick;
        chk("mul_accept_stall", EX_stall_out, 1);
        chk("mul_accept_valid", EX_valid_out, 0);
        drive(1, 3'b000, 32'h7, 32'h8, 7'h04);
        ok = 1'b1;
        repeat (32) begin
            tick;
            if (EX_valid_out !== 1'b0 || EX_stall_out !== 1'b1) ok = 1'b0;
        end
        chk("mul_busy_32", ok, 1);
        tick;
        chk_out("mul_done", 1, 32'h2345_0000, 7'h33);
        chk("mul_done_stall", EX_stall_out, 0);
        tick;
        chk_out("held_bundle", 1, 32'hF, 7'h04);
        drive(0, 3'b000, 0, 0, 0);
        tick;
        chk("mul_drain", EX_valid_out, 0);

        EX_stall_in = 1'b1;
        drive(1, 3'b111, 32'h7, 32'h6, 7'h05);
        tick;
        drive(0, 3'b000, 0, 0, 0);
        repeat (32) tick;
        tick;
        chk_out("mul_stalled_done", 1, 32'h2A, 7'h05);
        chk("mul_stalled_stall", EX_stall_out, 1);
        repeat (2) tick;
        chk_out("mul_stalled_hold", 1, 32'h2A, 7'h05);
        EX_stall_in = 1'b0;
        tick;
        chk_out("mul_stalled_consume", 0, 32'h2A, 7'h05);

        drive(1, 3'b111, 32'h3, 32'h3, 7'h06);
        tick;
        drive(0, 3'b000, 0, 0, 0);
        repeat (10) tick;
        reset = 1'b0;
        #1;
        chk_out("reset_mid_mul", 0, 32'h0, 7'h0);
        chk("reset_mid_mul_stall", EX_stall_out, 0);
        @(negedge clk);
        reset = 1'b1;
        ok = 1'b1;
        repeat (40) begin
            tick;
            if (EX_valid_out !== 1'b0 || EX_stall_out !== 1'b0) ok = 1'b0;
        end
        chk("no_spurious", ok, 1);
        drive(1, 3'b000, 32'h10, 32'h20, 7'h07);
        tick;
        chk_out("post_reset_add", 1, 32'h30, 7'h07);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have parameter REG_ADDRESS_SIZE, default 5, register address width.
REQ-002 SHALL have parameter REG_SIZE, default 32, data width.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 EX_valid_in  in  1  operand bundle from decode stage valid.
REQ-006 EX_operand1  in  REG_SIZE  first operand.
REQ-007 EX_operand2  in  REG_SIZE  second operand (register or immediate, already selected).
REQ-008 EX_op  in  3  operation: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT, 110 SLL, 111 MUL.
REQ-009 EX_static_in  in  REG_ADDRESS_SIZE+2  destination address plus 2 control bits, carried unmodified.
REQ-010 EX_stall_in  in  1  downstream cannot consume the output this cycle.
REQ-011 EX_stall_out  out  1  upstream must hold its bundle; this stage accepts nothing.
REQ-012 EX_valid_out  out  1  EX_result/EX_static_out hold a valid result.
REQ-013 EX_result  out  REG_SIZE  registered result.
REQ-014 EX_static_out  out  REG_ADDRESS_SIZE+2  registered copy of the accepted EX_static_in.

Function
REQ-015 SHALL accept a bundle at a rising edge where EX_valid_in=1 and EX_stall_out=0; otherwise inputs are ignored.
REQ-016 EX_stall_out SHALL be combinational: 1 when state=MUL, or when EX_valid_out=1 and EX_stall_in=1; else 0.
REQ-017 FSM states: IDLE, MUL; reset state IDLE.
REQ-018 Ops 000-110 accepted in IDLE SHALL load EX_result, EX_static_out and set EX_valid_out=1 at the acceptance edge (latency 1); state stays IDLE.
REQ-019 ADD/SUB SHALL wrap modulo 2^REG_SIZE; AND/OR/XOR bitwise; SLT signed compare, result 1 or 0 zero-extended; SLL shifts operand1 left by operand2[4:0], zero fill.
REQ-020 MUL SHALL produce the low REG_SIZE bits of operand1*operand2 via iterative shift-add, one multiplier bit per cycle.
REQ-021 MUL acceptance SHALL latch operands and EX_static_in, clear a 6-bit step counter and move IDLE->MUL.
REQ-022 Each MUL cycle SHALL process one bit and increment the counter until it reaches 32.
REQ-023 At counter=32, if the output register is free (EX_valid_out=0 or EX_stall_in=0), SHALL load EX_result/EX_static_out, set EX_valid_out=1, move MUL->IDLE; else SHALL hold in MUL with counter at 32.
REQ-024 Unstalled MUL latency: EX_valid_out rises 33 edges after acceptance edge.
REQ-025 At any edge where EX_valid_out=1 and EX_stall_in=0 with no new result loaded, EX_valid_out SHALL clear; EX_result/EX_static_out keep their values.
REQ-026 While EX_valid_out=1 and EX_stall_in=1, EX_result/EX_static_out/EX_valid_out SHALL be held unchanged.
REQ-027 Consumption and a new load at the same edge SHALL leave EX_valid_out=1 with the new result (back-to-back throughput one per cycle for ops 000-110).
REQ-028 EX_valid_in=1 while EX_stall_out=1 SHALL have no effect; no bundle is dropped or duplicated provided upstream holds.

Reset
REQ-029 reset=0 SHALL immediately force state IDLE, counter 0, EX_valid_out=0, EX_result=0, EX_static_out=0, independent of clk.
REQ-030 Reset asserted mid-MUL SHALL abort the multiply; no result is produced after release.
REQ-031 First acceptance possible at the first rising edge after reset=1.

Verification
REQ-032 ADD 0xFFFFFFFF+0x00000002, static 0x55 -> next edge EX_result=0x00000001, EX_static_out=0x55, EX_valid_out=1.
REQ-033 SLT 0xFFFFFFFF vs 0x00000001 -> EX_result=1; SLL 0x1 by 0x21 -> EX_result=0x00000002.
REQ-034 MUL 0x00012345*0x00010000 -> EX_stall_out=1 for 32 cycles, EX_valid_out at edge 33, EX_result=0x23450000.
REQ-035 EX_stall_in=1 held 5 cycles with EX_valid_out=1 -> EX_result stable, EX_stall_out=1, new bundle on EX_valid_in not accepted until EX_stall_in=0.
REQ-036 MUL completes while prior result stalled -> stage holds in MUL, loads result at first edge after EX_stall_in=0.
REQ-037 reset=0 at MUL step 10 -> all outputs 0 immediately; after release EX_stall_out=0, no spurious EX_valid_out.
